quant_table_loader: RTL

Controller that computes and loads the JPEG quantizer's reciprocal multiplier tables from an 8-bit quality scale. It writes 128 entries (64 luma, 64 chroma) into the shadow bank of the double-banked quant table RAM read by the quantizer. It swaps banks only at a frame boundary, so a frame in progress is never quantized with mixed tables. It sits between the host/register interface and the quantizer table RAM.

---
 rtl/quant_ctrl_pkg.sv | 62 ++++++
 rtl/quant_table_loader_if.sv | 31 +++
 rtl/quant_recip_div.sv | 74 +++++++
 rtl/quant_table_loader.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/quant_ctrl_pkg.sv
// rtl/quant_ctrl_pkg.sv - shared constants, base tables and FSM states for the quant table loader
//
// Purpose: base JPEG luma/chroma quantizer tables (quantizer read order,
// row-major 8x8), loader FSM state enum, arithmetic constants and small
// helper functions used by quant_table_loader and quant_recip_div.
// Ports: none (package).
package quant_ctrl_pkg;

    localparam int DIV_W      = 17;
    localparam int RECIP_NUM  = 65536;
    localparam int ROUND_BIAS = 50;
    localparam int SCALE_DIV  = 100;
    localparam int N_ENTRIES  = 128;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DIV1,
        CLAMP,
        DIV2,
        WRITE,
        DONE
    } qtl_state_e;

    localparam logic [7:0] LUMA_BASE [64] = '{
        8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
        8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
        8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
        8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
        8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
        8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
        8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
        8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
    };

    localparam logic [7:0] CHROMA_BASE [64] = '{
        8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
    };

    function automatic logic [7:0] base_q(input logic chroma, input logic [5:0] idx);
        return chroma ? CHROMA_BASE[idx] : LUMA_BASE[idx];
    endfunction

    // Scaled quantizer step must stay a legal nonzero 8-bit divisor.
    function automatic logic [7:0] clamp_q(input logic [DIV_W-1:0] quo);
        if (quo == '0) begin
            return 8'd1;
        end else if (quo > DIV_W'(255)) begin
            return 8'd255;
        end else begin
            return quo[7:0];
        end
    endfunction

endpackage

// File: rtl/quant_table_loader_if.sv
// rtl/quant_table_loader_if.sv - host control and table RAM write bundle for the quant table loader
//
// Signals: start/qscale/frame_start (host -> loader), busy/done/pending
// (status), wr_en/wr_addr/wr_data (table RAM write port), bank_sel (active
// bank read by the quantizer).
// Modports: master = loader side, slave = host/RAM/quantizer side.
interface quant_table_loader_if #(
    parameter int M_BITS = 13,
    parameter int QS_W   = 8
);
    logic              start;
    logic [QS_W-1:0]   qscale;
    logic              frame_start;
    logic              busy;
    logic              done;
    logic              pending;
    logic              wr_en;
    logic [7:0]        wr_addr;
    logic [M_BITS-1:0] wr_data;
    logic              bank_sel;

    modport master (
        input  start, qscale, frame_start,
        output busy, done, pending, wr_en, wr_addr, wr_data, bank_sel
    );

    modport slave (
        output start, qscale, frame_start,
        input  busy, done, pending, wr_en, wr_addr, wr_data, bank_sel
    );
endinterface

// File: rtl/quant_recip_div.sv
// rtl/quant_recip_div.sv - 17-bit by 8-bit restoring divider, one quotient bit per cycle
//
// Ports: clk, reset (sync, active-high); start_i loads dividend_i/divisor_i
// and performs the first step in the same cycle; quotient_o is final and
// valid_o pulses exactly 17 cycles after start_i. The quotient holds until
// the next start. divisor_i must be nonzero.
module quant_recip_div
    import quant_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [DIV_W-1:0] dividend_i,
    input  logic [7:0]       divisor_i,
    output logic [DIV_W-1:0] quotient_o,
    output logic             valid_o
);

    logic [7:0]       rem_q, rem_d;
    logic [DIV_W-1:0] quo_q, quo_d;
    logic [7:0]       dvs_q;
    logic [4:0]       cnt_q;
    logic             valid_q;

    logic [7:0]       rem_in;
    logic [DIV_W-1:0] quo_in;
    logic [7:0]       dvs;
    logic [8:0]       trial;
    logic             qbit;

    // The start cycle already does one step so that 17 steps finish 17 cycles later.
    always_comb begin
        rem_in = start_i ? 8'd0 : rem_q;
        quo_in = start_i ? dividend_i : quo_q;
        dvs    = start_i ? divisor_i : dvs_q;
        trial  = {rem_in, quo_in[DIV_W-1]};
        qbit   = 1'b0;
        rem_d  = trial[7:0];
        if (trial >= {1'b0, dvs}) begin
            qbit  = 1'b1;
            rem_d = 8'(trial - {1'b0, dvs});
        end
        quo_d = {quo_in[DIV_W-2:0], qbit};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (start_i) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                dvs_q <= divisor_i;
                cnt_q <= 5'(DIV_W - 1);
            end else if (cnt_q != 5'd0) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign quotient_o = quo_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/quant_table_loader.sv
// rtl/quant_table_loader.sv - computes reciprocal quant tables from qscale and loads the shadow bank
//
// Ports: clk, reset (sync, active-high); bus (quant_table_loader_if.master):
//   start/qscale  - load request, qscale latched on acceptance (0 treated as 1)
//   frame_start   - frame boundary; the only point where banks swap
//   busy/done     - load in progress / one-cycle completion pulse
//   pending       - shadow bank holds a finished load not yet swapped in
//   wr_en/wr_addr/wr_data - table RAM write: {shadow bank, chroma, idx}, factor
//   bank_sel      - active bank read by the quantizer
// Each entry: Q = clamp((Qb*qs+50)/100, 1, 255), factor = min((65536+Q/2)/Q, 2^M_BITS-1).
module quant_table_loader
    import quant_ctrl_pkg::*;
#(
    parameter int M_BITS = 13,
    parameter int QS_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    quant_table_loader_if.master bus
);

    localparam int MAX_F = (1 << M_BITS) - 1;

    qtl_state_e        state_q;
    logic [6:0]        k_q;
    logic [QS_W-1:0]   qs_q;
    logic              busy_q;
    logic              done_q;
    logic              pending_q;
    logic              wr_en_q;
    logic [7:0]        wr_addr_q;
    logic [M_BITS-1:0] wr_data_q;
    logic              bank_sel_q;

    logic              div_start;
    logic [DIV_W-1:0]  div_dividend;
    logic [7:0]        div_divisor;
    logic [DIV_W-1:0]  div_quo;
    logic              div_valid;

    logic [7:0]        qb;
    logic [7:0]        q_clamped;
    logic [DIV_W-1:0]  num1;
    logic [DIV_W-1:0]  num2;
    logic [M_BITS-1:0] factor;
    logic              swap;

    // One divider serves both divisions: scaling in FETCH, reciprocal in CLAMP.
    always_comb begin
        qb           = base_q(k_q[6], k_q[5:0]);
        num1         = DIV_W'(qb) * DIV_W'(qs_q) + DIV_W'(ROUND_BIAS);
        q_clamped    = clamp_q(div_quo);
        num2         = DIV_W'(RECIP_NUM) + DIV_W'(q_clamped >> 1);
        div_start    = (state_q == FETCH) || (state_q == CLAMP);
        div_dividend = (state_q == CLAMP) ? num2 : num1;
        div_divisor  = (state_q == CLAMP) ? q_clamped : 8'(SCALE_DIV);
        factor       = (div_quo > DIV_W'(MAX_F)) ? M_BITS'(MAX_F) : div_quo[M_BITS-1:0];
        // pending only rises the cycle after done, so a frame_start
        // coinciding with done cannot swap in the fresh tables.
        swap         = bus.frame_start && pending_q && !busy_q;
    end

    quant_recip_div u_div (
        .clk        (clk),
        .reset      (reset),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .quotient_o (div_quo),
        .valid_o    (div_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            qs_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pending_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            bank_sel_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;

            // Swap is evaluated before the FSM so a simultaneous start
            // loads the bank that has just become the shadow.
            if (swap) begin
                bank_sel_q <= ~bank_sel_q;
                pending_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        qs_q      <= (bus.qscale == '0) ? QS_W'(1) : bus.qscale;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                        k_q       <= '0;
                        state_q   <= FETCH;
                    end
                end
                FETCH: begin
                    state_q <= DIV1;
                end
                DIV1: begin
                    if (div_valid) begin
                        state_q <= CLAMP;
                    end
                end
                CLAMP: begin
                    state_q <= DIV2;
                end
                DIV2: begin
                    // Write strobe is registered so it is high during WRITE.
                    if (div_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= {~bank_sel_q, k_q};
                        wr_data_q <= factor;
                        state_q   <= WRITE;
                    end
                end
                WRITE: begin
                    if (k_q == 7'(N_ENTRIES - 1)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        k_q     <= k_q + 7'd1;
                        state_q <= FETCH;
                    end
                end
                DONE: begin
                    pending_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pending  = pending_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.bank_sel = bank_sel_q;

endmodule
